// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues req/ack reads at the current PC, steers the
// PC's next value, and delivers words into a valid/stall IF/ID register via a one-entry skid buffer.
module fetch_stage #(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            id_stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]      state;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] drain_addr;
  logic [XLEN-1:0] pc_inc;
  logic            slot_free;

  assign slot_free = !if_valid || !id_stall;
  assign pc_inc    = pc + XLEN'(PC_STEP);

  // FULL owns a word already, so no request may be outstanding there.
  assign imem_req  = !reset && (state != FULL);
  // DRAIN keeps presenting the abandoned address; pc already holds the redirect target.
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

  // The PC register loads every edge, so "hold" must be driven explicitly.
  always_comb begin
    // NOTE: default first so every path assigns next_pc and no latch is inferred.
    next_pc = pc;
    if (!reset) begin
      if (branch_taken)
        next_pc = branch_target;
      else if (state == FETCH && imem_ack)
        next_pc = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= FETCH;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      drain_addr <= '0;
    end else if (branch_taken) begin
      // Flush: IF/ID and skid contents are dropped, any same-cycle ack is discarded.
      if_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (!imem_ack) begin
            state      <= DRAIN;
            drain_addr <= pc;
          end
        end
        DRAIN: begin
          if (imem_ack) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            if (slot_free) begin
              if_valid <= 1'b1;
              if_instr <= imem_rdata;
              if_pc    <= pc;
            end else begin
              skid_instr <= imem_rdata;
              skid_pc    <= pc;
              state      <= FULL;
            end
          end else if (slot_free) begin
            if_valid <= 1'b0;
          end
        end
        FULL: begin
          if (slot_free) begin
            if_valid <= 1'b1;
            if_instr <= skid_instr;
            if_pc    <= skid_pc;
            state    <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) state <= FETCH;
          if (slot_free) if_valid <= 1'b0;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/branch/reset/latency traffic, checked against a queue-based model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        id_stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.XLEN(32), .PC_STEP(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .next_pc      (next_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .id_stall     (id_stall),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc)
  );

  always #5 clk = ~clk;

  // Memory contents: a distinct word per address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf ^ {a[31:16], 16'h0};
  endfunction

  // Reference model: words held downstream (front = IF/ID), fetch PC, drain state.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      held[$];
  logic [31:0] model_pc = '0;
  bit          draining = 1'b0;
  logic [31:0] drain_addr = '0;

  // Memory behaviour: latency chosen per request (-1 selects random 0..2).
  int          mem_lat = 0;
  bit          mem_busy = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = '0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic cycle(input bit rst, input bit stall, input bit br, input logic [31:0] tgt);
    logic        exp_req;
    logic [31:0] exp_next;
    logic [31:0] nxt;
    bit          accepted;
    reset         = rst;
    id_stall      = stall;
    branch_taken  = br;
    branch_target = tgt;
    imem_ack      = 1'b0;
    imem_rdata    = $urandom;
    #1;
    exp_req = !rst && (held.size() < 2);
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, draining ? drain_addr : model_pc);
    if (mem_busy && !rst) check("addr_stable", imem_addr, mem_addr);
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_wait = (mem_lat < 0) ? int'($urandom_range(0, 2)) : mem_lat;
      end
      if (mem_wait == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = word_at(mem_addr);
      end else begin
        mem_wait--;
      end
    end
    #1;
    accepted = exp_req && imem_ack && !draining;
    if (rst)           exp_next = model_pc;
    else if (br)       exp_next = tgt;
    else if (accepted) exp_next = model_pc + 32'd4;
    else               exp_next = model_pc;
    check("next_pc", next_pc, exp_next);
    nxt = next_pc;

    @(posedge clk);
    if (rst || imem_ack) mem_busy = 1'b0;
    if (rst) begin
      held.delete();
      draining = 1'b0;
      model_pc = '0;
    end else if (br) begin
      held.delete();
      if (imem_ack) draining = 1'b0;
      else if (exp_req && !draining) begin
        draining   = 1'b1;
        drain_addr = model_pc;
      end
      model_pc = tgt;
    end else begin
      if (held.size() > 0 && !stall) void'(held.pop_front());
      if (imem_ack) begin
        if (draining) draining = 1'b0;
        else begin
          held.push_back('{pc: model_pc, instr: word_at(model_pc)});
          model_pc = model_pc + 32'd4;
        end
      end
    end
    #1;
    pc       = rst ? 32'h0 : nxt;
    imem_ack = 1'b0;
    check("if_valid", 32'(if_valid), 32'(held.size() > 0));
    if (held.size() > 0) begin
      check("if_pc", if_pc, held[0].pc);
      check("if_instr", if_instr, held[0].instr);
    end
  endtask

  initial begin
    // Reset and post-reset register state.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);

    // Zero-wait stream 0,4,8, then stall with ack for 0xC into the skid buffer.
    mem_lat = 0;
    cycle(0, 0, 0, 0);
    check("zw_pc0", if_pc, 32'h0);
    cycle(0, 0, 0, 0);
    check("zw_pc4", if_pc, 32'h4);
    cycle(0, 0, 0, 0);
    check("zw_pc8", if_pc, 32'h8);
    cycle(0, 1, 0, 0);
    check("skid_pc", pc, 32'h10);
    check("skid_req", 32'(imem_req), 32'h0);
    check("skid_hold", if_pc, 32'h8);
    cycle(0, 0, 0, 0);
    check("skid_release", if_pc, 32'hc);
    cycle(0, 0, 0, 0);
    check("skid_resume", if_pc, 32'h10);

    // Two-cycle memory latency.
    mem_lat = 2;
    repeat (9) cycle(0, 0, 0, 0);

    // Redirect while a request is outstanding: the late ack is discarded.
    mem_lat = 3;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h100);
    check("redir_flush", 32'(if_valid), 32'h0);
    mem_lat = 0;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("redir_drain", 32'(if_valid), 32'h0);
    cycle(0, 0, 0, 0);
    check("redir_target", if_pc, 32'h100);

    // Ack and branch together.
    cycle(0, 0, 1, 32'h200);
    check("ackbr_flush", 32'(if_valid), 32'h0);
    cycle(0, 0, 0, 0);
    check("ackbr_target", if_pc, 32'h200);

    // Branch while the skid buffer is full.
    cycle(0, 1, 0, 0);
    check("full_req", 32'(imem_req), 32'h0);
    cycle(0, 1, 1, 32'h300);
    check("fullbr_flush", 32'(if_valid), 32'h0);
    cycle(0, 0, 0, 0);
    check("fullbr_target", if_pc, 32'h300);

    // PC wrap at the top of the address space.
    cycle(0, 0, 1, 32'hffff_fffc);
    cycle(0, 0, 0, 0);
    check("wrap_top", if_pc, 32'hffff_fffc);
    cycle(0, 0, 0, 0);
    check("wrap_zero", if_pc, 32'h0);

    // Reset in the middle of an outstanding request.
    mem_lat = 3;
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("rstmid_valid", 32'(if_valid), 32'h0);
    check("rstmid_pc", pc, 32'h0);
    mem_lat = 0;
    cycle(0, 0, 0, 0);
    check("rstmid_restart", if_pc, 32'h0);

    // Random traffic.
    mem_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? 32'hffff_fffc : ($urandom & 32'h0000_0ffc);
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 3,
            $urandom_range(0, 19) == 0, tgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the program counter register.
- Takes the registered PC value and issues a request/acknowledge read to instruction memory.
- Delivers the fetched word with its PC into a valid/stall IF/ID output register, through a one-entry skid buffer.
- Drives the PC's next-value input combinationally: hold, PC+4, or branch target. The PC loads every clock, so this block must drive the hold value when it wants the PC to stay put.

Parameters:
- XLEN, 32, width of PC, addresses and instruction words.
- PC_STEP, 4, byte increment applied per accepted instruction.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; also resets the PC register and instruction memory.
- pc  in  XLEN  current PC from the program counter register.
- next_pc  out  XLEN  value the PC loads at the next edge (combinational).
- imem_req  out  1  read request; held high until imem_ack.
- imem_addr  out  XLEN  read address; equals pc.
- imem_ack  in  1  one-cycle acknowledge; allowed in the same cycle as req (zero-wait) or any later cycle.
- imem_rdata  in  XLEN  instruction word; valid only when imem_ack=1.
- branch_taken  in  1  redirect/flush request from a later stage.
- branch_target  in  XLEN  redirect address.
- id_stall  in  1  decode cannot accept; hold the IF/ID register.
- if_valid  out  1  IF/ID register holds a valid instruction.
- if_instr  out  XLEN  registered instruction.
- if_pc  out  XLEN  PC of if_instr.

Behaviour:
- Reset is synchronous and active-high. On a clock edge with reset=1:
  - State goes to FETCH.
  - if_valid, if_instr and if_pc go to 0.
  - The skid buffer is cleared.
  - imem_req is 0 while reset=1.
  - next_pc = pc.
- Reset mid-request abandons the outstanding access. Memory is reset on the same edge, so no stale ack follows.
- Slot free: slot_free = !if_valid || !id_stall.
- States:
  - FETCH:
    - imem_req=1 and imem_addr=pc.
    - Ack with slot_free: load IF/ID (if_instr=rdata, if_pc=pc, if_valid=1); next_pc=pc+PC_STEP; stay in FETCH.
    - Back-to-back zero-wait acks therefore give one instruction per cycle.
    - Ack without slot_free: capture {rdata, pc} into the skid buffer; next_pc=pc+PC_STEP; go to FULL.
    - No ack: next_pc=pc.
  - FULL:
    - imem_req=0.
    - When slot_free: move the buffer into IF/ID (if_valid=1), clear the buffer, go to FETCH.
    - next_pc=pc in FULL; the PC already advanced on entry.
  - DRAIN:
    - imem_req=1 with unchanged imem_addr, so the request remains legal while its result is discarded.
    - On ack: discard rdata, go to FETCH.
    - next_pc=pc.
- PC hold in DRAIN: the PC already holds the redirect target. The request in flight is for the old address, so imem_addr must stay equal to the latched old address. Implementation: a DRAIN-address register captured on entry to DRAIN. imem_addr = that register in DRAIN, = pc otherwise.
- branch_taken has highest priority in every state:
  - next_pc = branch_target.
  - IF/ID is flushed: if_valid=0 at the next edge, regardless of id_stall.
  - The skid buffer is cleared.
  - Any ack in the same cycle is discarded.
  - Next state:
    - FETCH without ack -> DRAIN.
    - FETCH with ack -> FETCH.
    - FULL -> FETCH.
    - DRAIN without ack -> DRAIN.
    - DRAIN with ack -> FETCH.
  - The DRAIN address is unchanged by a further redirect.
- IF/ID with no new word:
  - if_valid && !id_stall -> if_valid=0.
  - if_valid && id_stall -> all of if_valid, if_instr, if_pc hold.
- Arithmetic: pc+PC_STEP is truncated to XLEN. 0xFFFFFFFC+4 wraps to 0 with no flag.
- Invariants:
  - imem_addr is stable while imem_req is high and un-acked.
  - At most one outstanding request.
  - The IF/ID register and skid buffer together never hold more than 2 words.
  - Instructions appear at if_pc in program order, with no duplicates or drops except on a flush.

Test Plan:
- Zero-wait stream: ack=1 every cycle, no stall, from reset -> if_pc = 0,4,8,12 on consecutive cycles, if_valid=1 from the 2nd edge, next_pc leads by 4.
- Two-cycle memory latency: ack every 3rd cycle -> pc holds 0 for 3 cycles; if_pc=0 then 4; imem_addr stable throughout each request.
- Stall/skid: with if_valid=1 (if_pc=0x8), id_stall=1 and ack for 0xC -> state FULL, pc=0x10, imem_req=0; release stall -> if_pc=0xC the next edge, then fetch of 0x10 resumes.
- Redirect in flight: request to 0x20 outstanding, branch_taken with target 0x100 -> if_valid=0; next ack discarded; following fetch uses imem_addr=0x100 and if_pc=0x100 appears.
- Simultaneous ack+branch and branch while in FULL -> no word from the old path reaches IF/ID; first valid if_pc = branch_target.
- Reset mid-request and PC wrap: reset during an outstanding request -> imem_req=0 and if_valid=0 next cycle, fetch restarts at 0. Redirect to 0xFFFFFFFC -> following if_pc = 0x0.
